// File: rtl/dll_ctl_pkg.sv
// Shared types and helpers for the DLL code tracker: FSM state encoding,
// error counter width and a counter-width helper.
package dll_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    WAIT_LOCK,
    UPDATE,
    SETTLE,
    PUBLISH,
    TRACK
  } dll_state_t;

  localparam int ERR_W = 8;

  // Bits needed to hold values 0..max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dll_code_tracker_if.sv
// Code distribution bus between the tracker (master) and its delay-line
// consumers (slave): shared code plus per-channel req/ack.
interface dll_code_tracker_if #(
  parameter int CODE_W = 8,
  parameter int NUM_CH = 2
);

  logic [CODE_W-1:0] code_out;
  logic [NUM_CH-1:0] ch_upd_req;
  logic [NUM_CH-1:0] ch_upd_ack;

  modport master (output code_out, output ch_upd_req, input ch_upd_ack);
  modport slave  (input code_out, input ch_upd_req, output ch_upd_ack);

endinterface

// File: rtl/dll_lock_filter.sv
// DLL lock qualifier: counts consecutive lock-high cycles while armed and
// flags a lock loss after two consecutive lock-low cycles.
module dll_lock_filter
  import dll_ctl_pkg::*;
#(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic dll_lock,
  output logic lock_ok,
  output logic lock_loss
);

  localparam int FW = cnt_width(LOCK_FILT);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

  logic [FW-1:0] high_cnt;
  logic          low_q;

  // The high counter only runs while armed, so lock seen during power-up
  // never counts towards the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_cnt <= '0;
      low_q    <= 1'b0;
    end else begin
      low_q <= ~dll_lock;
      if (!enable || !dll_lock) begin
        high_cnt <= '0;
      end else if (high_cnt != FILT_LAST) begin
        high_cnt <= high_cnt + 1'b1;
      end
    end
  end

  assign lock_ok   = enable && dll_lock && (high_cnt == FILT_LAST);
  assign lock_loss = ~dll_lock & low_q;

endmodule

// File: rtl/dll_code_tracker.sv
// DLL code manager: sequences DLL power-up, qualifies lock, refreshes and
// filters the delay code, and publishes it to NUM_CH consumers via req/ack.
module dll_code_tracker
  import dll_ctl_pkg::*;
#(
  parameter int CODE_W       = 8,
  parameter int NUM_CH       = 2,
  parameter int PWRUP_WAIT   = 64,
  parameter int LOCK_FILT    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CODE_SETTLE  = 4,
  parameter int UPD_PERIOD   = 1024,
  parameter int HYST         = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dll_lock,
  input  logic              dll_delay_diff,
  input  logic [CODE_W-1:0] dll_code,
  output logic              dll_powerdown_n,
  output logic              dll_code_update,
  output logic              locked,
  output logic              lock_lost,
  output logic [ERR_W-1:0]  err_cnt,
  dll_code_tracker_if.master ch_bus
);

  localparam int MAX_A   = (PWRUP_WAIT > CODE_SETTLE) ? PWRUP_WAIT : CODE_SETTLE;
  localparam int MAX_B   = (LOCK_TIMEOUT > UPD_PERIOD) ? LOCK_TIMEOUT : UPD_PERIOD;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int DW      = CODE_W + 1;

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_WAIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(CODE_SETTLE - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(UPD_PERIOD - 1);
  localparam logic [DW-1:0]    HYST_W       = DW'(HYST);

  dll_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [NUM_CH-1:0] req_q, req_n;
  logic              locked_q, locked_n;
  logic              first_q, first_n;
  logic              lost_q, lost_n;
  logic              pdn_q, upd_q;
  logic [ERR_W-1:0]  err_q;
  logic              err_inc;

  logic              lock_ok, lock_loss, lock_active;
  logic [DW-1:0]     cap_ext, pub_ext, code_diff;

  dll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == WAIT_LOCK),
    .dll_lock  (dll_lock),
    .lock_ok   (lock_ok),
    .lock_loss (lock_loss)
  );

  // Unsigned distance between the freshly settled code and the published one.
  assign cap_ext     = {1'b0, dll_code};
  assign pub_ext     = {1'b0, code_q};
  assign code_diff   = (cap_ext >= pub_ext) ? (cap_ext - pub_ext) : (pub_ext - cap_ext);
  assign lock_active = (state inside {UPDATE, SETTLE, PUBLISH, TRACK});

  // Next-state logic; disable beats lock loss, which beats normal sequencing.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    code_n   = code_q;
    req_n    = req_q;
    locked_n = locked_q;
    first_n  = first_q;
    lost_n   = 1'b0;
    err_inc  = 1'b0;

    if (!enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      req_n    = '0;
      locked_n = 1'b0;
      first_n  = 1'b1;
    end else if (lock_active && lock_loss) begin
      state_n  = WAIT_LOCK;
      cnt_n    = '0;
      req_n    = '0;
      locked_n = 1'b0;
      lost_n   = 1'b1;
      err_inc  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n = PWRUP;
          cnt_n   = '0;
        end
        PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            state_n = UPDATE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
            err_inc = 1'b1;
          end
        end
        UPDATE: begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt_n = '0;
            if (first_q || (code_diff > HYST_W)) begin
              code_n  = dll_code;
              req_n   = '1;
              first_n = 1'b0;
              state_n = PUBLISH;
            end else begin
              state_n = TRACK;
            end
          end
        end
        PUBLISH: begin
          req_n = req_q & ~ch_bus.ch_upd_ack;
          if (req_q == '0) begin
            locked_n = 1'b1;
            state_n  = TRACK;
            cnt_n    = '0;
          end
        end
        TRACK: begin
          if (dll_delay_diff || (cnt == PERIOD_LAST)) begin
            state_n = UPDATE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      code_q   <= '0;
      req_q    <= '0;
      locked_q <= 1'b0;
      first_q  <= 1'b1;
      lost_q   <= 1'b0;
      pdn_q    <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      code_q   <= code_n;
      req_q    <= req_n;
      locked_q <= locked_n;
      first_q  <= first_n;
      lost_q   <= lost_n;
      pdn_q    <= (state_n != IDLE);
      upd_q    <= (state_n == UPDATE);
      if (err_inc && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign dll_powerdown_n   = pdn_q;
  assign dll_code_update   = upd_q;
  assign locked            = locked_q;
  assign lock_lost         = lost_q;
  assign err_cnt           = err_q;
  assign ch_bus.code_out   = code_q;
  assign ch_bus.ch_upd_req = req_q;

endmodule

// File: tb/tb_dll_code_tracker.sv
// Directed bench for dll_code_tracker with short timing parameters; each task
// exercises one scenario and checks outputs at exact cycle offsets.
module tb_dll_code_tracker;
  import dll_ctl_pkg::*;

  localparam int CODE_W = 8;
  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              dll_lock;
  logic              dll_delay_diff;
  logic [CODE_W-1:0] dll_code;
  logic              dll_powerdown_n;
  logic              dll_code_update;
  logic              locked;
  logic              lock_lost;
  logic [ERR_W-1:0]  err_cnt;

  int checks = 0;
  int passes = 0;

  dll_code_tracker_if #(.CODE_W(CODE_W), .NUM_CH(NUM_CH)) ch_bus ();

  dll_code_tracker #(
    .CODE_W(CODE_W), .NUM_CH(NUM_CH), .PWRUP_WAIT(4), .LOCK_FILT(3),
    .LOCK_TIMEOUT(32), .CODE_SETTLE(2), .UPD_PERIOD(16), .HYST(1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .dll_lock        (dll_lock),
    .dll_delay_diff  (dll_delay_diff),
    .dll_code        (dll_code),
    .dll_powerdown_n (dll_powerdown_n),
    .dll_code_update (dll_code_update),
    .locked          (locked),
    .lock_lost       (lock_lost),
    .err_cnt         (err_cnt),
    .ch_bus          (ch_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after an edge; outputs are read there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; dll_lock = 1'b0; dll_delay_diff = 1'b0;
    dll_code = '0; ch_bus.ch_upd_ack = '0;
    tick(3);
    checks++; if (dll_powerdown_n !== 1'b0) $display("[TB] FAIL reset_pdn: got %b want 0", dll_powerdown_n); else passes++;
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL reset_upd: got %b want 0", dll_code_update); else passes++;
    checks++; if (ch_bus.code_out !== 8'h00) $display("[TB] FAIL reset_code: got %h want 00", ch_bus.code_out); else passes++;
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL reset_req: got %b want 00", ch_bus.ch_upd_req); else passes++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL reset_locked: got %b want 0", locked); else passes++;
    checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL reset_lost: got %b want 0", lock_lost); else passes++;
    checks++; if (err_cnt !== 8'd0) $display("[TB] FAIL reset_err: got %0d want 0", err_cnt); else passes++;
    reset = 1'b0;
    tick(2);
    checks++; if (dll_powerdown_n !== 1'b0) $display("[TB] FAIL idle_pdn: got %b want 0", dll_powerdown_n); else passes++;
  endtask

  task automatic test_bringup();
    enable = 1'b1; dll_lock = 1'b1; dll_code = 8'h40;
    tick(1);
    checks++; if (dll_powerdown_n !== 1'b1) $display("[TB] FAIL bringup_pdn: got %b want 1", dll_powerdown_n); else passes++;
    tick(6);
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL bringup_upd_early: got %b want 0", dll_code_update); else passes++;
    tick(1);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL bringup_upd: got %b want 1", dll_code_update); else passes++;
    tick(1);
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL bringup_upd_single: got %b want 0", dll_code_update); else passes++;
    tick(2);
    checks++; if (ch_bus.code_out !== 8'h40) $display("[TB] FAIL bringup_code: got %h want 40", ch_bus.code_out); else passes++;
    checks++; if (ch_bus.ch_upd_req !== 2'b11) $display("[TB] FAIL bringup_req: got %b want 11", ch_bus.ch_upd_req); else passes++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL bringup_locked_early: got %b want 0", locked); else passes++;
    ch_bus.ch_upd_ack = 2'b01;
    tick(1);
    ch_bus.ch_upd_ack = 2'b00;
    checks++; if (ch_bus.ch_upd_req !== 2'b10) $display("[TB] FAIL bringup_ack0: got %b want 10", ch_bus.ch_upd_req); else passes++;
    tick(1);
    checks++; if (ch_bus.ch_upd_req !== 2'b10) $display("[TB] FAIL bringup_req_hold: got %b want 10", ch_bus.ch_upd_req); else passes++;
    ch_bus.ch_upd_ack = 2'b10;
    tick(1);
    ch_bus.ch_upd_ack = 2'b00;
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL bringup_ack1: got %b want 00", ch_bus.ch_upd_req); else passes++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL bringup_locked_pre: got %b want 0", locked); else passes++;
    tick(1);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL bringup_locked: got %b want 1", locked); else passes++;
  endtask

  task automatic test_hysteresis();
    dll_code = 8'h41;
    tick(15);
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL hyst_upd_early: got %b want 0", dll_code_update); else passes++;
    tick(1);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL hyst_upd: got %b want 1", dll_code_update); else passes++;
    tick(3);
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL hyst_no_req: got %b want 00", ch_bus.ch_upd_req); else passes++;
    checks++; if (ch_bus.code_out !== 8'h40) $display("[TB] FAIL hyst_code_kept: got %h want 40", ch_bus.code_out); else passes++;
    dll_code = 8'h3E;
    tick(16);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL hyst_upd2: got %b want 1", dll_code_update); else passes++;
    tick(3);
    checks++; if (ch_bus.code_out !== 8'h3E) $display("[TB] FAIL hyst_code_pub: got %h want 3e", ch_bus.code_out); else passes++;
    checks++; if (ch_bus.ch_upd_req !== 2'b11) $display("[TB] FAIL hyst_req_pub: got %b want 11", ch_bus.ch_upd_req); else passes++;
    ch_bus.ch_upd_ack = 2'b11;
    tick(1);
    ch_bus.ch_upd_ack = 2'b00;
    tick(1);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL hyst_locked: got %b want 1", locked); else passes++;
  endtask

  task automatic test_drift();
    tick(4);
    dll_delay_diff = 1'b1;
    tick(1);
    dll_delay_diff = 1'b0;
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL drift_upd: got %b want 1", dll_code_update); else passes++;
    tick(1);
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL drift_upd_single: got %b want 0", dll_code_update); else passes++;
    tick(2);
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL drift_no_req: got %b want 00", ch_bus.ch_upd_req); else passes++;
    tick(15);
    checks++; if (dll_code_update !== 1'b0) $display("[TB] FAIL drift_restart_early: got %b want 0", dll_code_update); else passes++;
    tick(1);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL drift_restart_upd: got %b want 1", dll_code_update); else passes++;
    tick(3);
  endtask

  task automatic test_lock_glitch();
    dll_lock = 1'b0;
    tick(1);
    dll_lock = 1'b1;
    checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL glitch_lost0: got %b want 0", lock_lost); else passes++;
    tick(1);
    checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL glitch_lost1: got %b want 0", lock_lost); else passes++;
    checks++; if (locked !== 1'b1) $display("[TB] FAIL glitch_locked: got %b want 1", locked); else passes++;
    checks++; if (err_cnt !== 8'd0) $display("[TB] FAIL glitch_err: got %0d want 0", err_cnt); else passes++;
  endtask

  task automatic test_lock_loss();
    dll_code = 8'h50;
    tick(14);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL loss_upd: got %b want 1", dll_code_update); else passes++;
    tick(3);
    checks++; if (ch_bus.ch_upd_req !== 2'b11) $display("[TB] FAIL loss_req_pub: got %b want 11", ch_bus.ch_upd_req); else passes++;
    dll_lock = 1'b0;
    tick(1);
    checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL loss_first_low: got %b want 0", lock_lost); else passes++;
    tick(1);
    checks++; if (lock_lost !== 1'b1) $display("[TB] FAIL loss_pulse: got %b want 1", lock_lost); else passes++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL loss_locked: got %b want 0", locked); else passes++;
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL loss_req_clr: got %b want 00", ch_bus.ch_upd_req); else passes++;
    checks++; if (err_cnt !== 8'd1) $display("[TB] FAIL loss_err: got %0d want 1", err_cnt); else passes++;
    checks++; if (ch_bus.code_out !== 8'h50) $display("[TB] FAIL loss_code: got %h want 50", ch_bus.code_out); else passes++;
    tick(1);
    checks++; if (lock_lost !== 1'b0) $display("[TB] FAIL loss_pulse_end: got %b want 0", lock_lost); else passes++;
  endtask

  task automatic test_timeout();
    tick(30);
    checks++; if (dll_powerdown_n !== 1'b1) $display("[TB] FAIL timeout_pdn_pre: got %b want 1", dll_powerdown_n); else passes++;
    checks++; if (err_cnt !== 8'd1) $display("[TB] FAIL timeout_err_pre: got %0d want 1", err_cnt); else passes++;
    tick(1);
    checks++; if (dll_powerdown_n !== 1'b0) $display("[TB] FAIL timeout_pdn_low: got %b want 0", dll_powerdown_n); else passes++;
    checks++; if (err_cnt !== 8'd2) $display("[TB] FAIL timeout_err: got %0d want 2", err_cnt); else passes++;
    tick(1);
    checks++; if (dll_powerdown_n !== 1'b1) $display("[TB] FAIL timeout_pdn_back: got %b want 1", dll_powerdown_n); else passes++;
  endtask

  task automatic test_enable_off();
    dll_lock = 1'b1;
    tick(7);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL enoff_upd: got %b want 1", dll_code_update); else passes++;
    tick(1);
    enable = 1'b0;
    tick(1);
    checks++; if (dll_powerdown_n !== 1'b0) $display("[TB] FAIL enoff_pdn: got %b want 0", dll_powerdown_n); else passes++;
    tick(3);
    checks++; if (ch_bus.ch_upd_req !== 2'b00) $display("[TB] FAIL enoff_no_req: got %b want 00", ch_bus.ch_upd_req); else passes++;
    checks++; if (ch_bus.code_out !== 8'h50) $display("[TB] FAIL enoff_code: got %h want 50", ch_bus.code_out); else passes++;
    enable = 1'b1;
    dll_code = 8'h50;
    tick(1);
    checks++; if (dll_powerdown_n !== 1'b1) $display("[TB] FAIL reen_pdn: got %b want 1", dll_powerdown_n); else passes++;
    tick(7);
    checks++; if (dll_code_update !== 1'b1) $display("[TB] FAIL reen_upd: got %b want 1", dll_code_update); else passes++;
    tick(3);
    checks++; if (ch_bus.ch_upd_req !== 2'b11) $display("[TB] FAIL reen_first_pub: got %b want 11", ch_bus.ch_upd_req); else passes++;
    checks++; if (ch_bus.code_out !== 8'h50) $display("[TB] FAIL reen_code: got %h want 50", ch_bus.code_out); else passes++;
    ch_bus.ch_upd_ack = 2'b11;
    tick(1);
    ch_bus.ch_upd_ack = 2'b00;
    tick(1);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL reen_locked: got %b want 1", locked); else passes++;
    checks++; if (err_cnt !== 8'd2) $display("[TB] FAIL reen_err: got %0d want 2", err_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_hysteresis();
    test_drift();
    test_lock_glitch();
    test_lock_loss();
    test_timeout();
    test_enable_off();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
